// File: rtl/filter_tap_controller.sv
// Double-buffered coefficient loader: taps are staged in a shadow bank, snapshotted on commit,
// then streamed into the filter one per cycle followed by a single flush/done pulse.
module filter_tap_controller #(
    parameter int N_TAPS    = 9,
    parameter int TAP_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           cfg_address,
    input  logic [TAP_WIDTH-1:0] cfg_data,
    input  logic                 cfg_we,
    input  logic                 commit,
    input  logic                 up_valid,
    output logic                 up_ready,
    output logic                 filt_valid,
    input  logic                 filt_ready,
    output logic [3:0]           tap_address,
    output logic [TAP_WIDTH-1:0] tap_data,
    output logic                 tap_we,
    output logic                 pipeline_flush,
    output logic                 busy,
    output logic                 done
);

    localparam logic [3:0] LAST_TAP = 4'(N_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_counter;
    logic                   r_pending;
    logic [TAP_WIDTH-1:0]   r_shadow [N_TAPS];
    logic [TAP_WIDTH-1:0]   r_active [N_TAPS];

    logic                   r_tap_we;
    logic [3:0]             r_tap_address;
    logic [TAP_WIDTH-1:0]   r_tap_data;
    logic                   r_pipeline_flush;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_load_start;
    logic                   w_idle;
    logic [TAP_WIDTH-1:0]   w_tap_sel;

    assign w_idle       = (r_state == IDLE);
    assign w_load_start = w_idle && (commit || r_pending);

    // Per-entry banks; the snapshot forwards a same-cycle shadow write so it is not lost.
    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_bank
            logic w_hit;
            assign w_hit = cfg_we && (cfg_address == 4'(gi));

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_shadow[gi] <= '0;
                end else if (w_hit) begin
                    r_shadow[gi] <= cfg_data;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_active[gi] <= '0;
                end else if (w_load_start) begin
                    r_active[gi] <= w_hit ? cfg_data : r_shadow[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        w_tap_sel = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            if (r_counter == 4'(i)) begin
                w_tap_sel = r_active[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_counter        <= '0;
            r_pending        <= 1'b0;
            r_tap_we         <= 1'b0;
            r_tap_address    <= '0;
            r_tap_data       <= '0;
            r_pipeline_flush <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_busy <= !w_idle;
            case (r_state)
                IDLE: begin
                    r_tap_we         <= 1'b0;
                    r_pipeline_flush <= 1'b0;
                    r_done           <= 1'b0;
                    if (commit || r_pending) begin
                        r_pending <= 1'b0;
                        r_counter <= '0;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (commit) begin
                        r_pending <= 1'b1;
                    end
                    r_tap_we      <= 1'b1;
                    r_tap_address <= r_counter;
                    r_tap_data    <= w_tap_sel;
                    r_counter     <= r_counter + 4'd1;
                    if (r_counter == LAST_TAP) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (commit) begin
                        r_pending <= 1'b1;
                    end
                    r_tap_we         <= 1'b0;
                    r_pipeline_flush <= 1'b1;
                    r_done           <= 1'b1;
                    r_state          <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake passes straight through only while no load is in progress.
    assign filt_valid     = w_idle && up_valid;
    assign up_ready       = w_idle && filt_ready;
    assign tap_we         = r_tap_we;
    assign tap_address    = r_tap_address;
    assign tap_data       = r_tap_data;
    assign pipeline_flush = r_pipeline_flush;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule

// File: tb/tb_filter_tap_controller.sv
// Randomized bench for filter_tap_controller against a timeline model of load sequences.
module tb_filter_tap_controller;

    localparam int N  = 9;
    localparam int TW = 16;

    logic          clock;
    logic          reset;
    logic [3:0]    cfg_address;
    logic [TW-1:0] cfg_data;
    logic          cfg_we;
    logic          commit;
    logic          up_valid;
    logic          up_ready;
    logic          filt_valid;
    logic          filt_ready;
    logic [3:0]    tap_address;
    logic [TW-1:0] tap_data;
    logic          tap_we;
    logic          pipeline_flush;
    logic          busy;
    logic          done;

    filter_tap_controller #(.N_TAPS(N), .TAP_WIDTH(TW)) dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_address    (cfg_address),
        .cfg_data       (cfg_data),
        .cfg_we         (cfg_we),
        .commit         (commit),
        .up_valid       (up_valid),
        .up_ready       (up_ready),
        .filt_valid     (filt_valid),
        .filt_ready     (filt_ready),
        .tap_address    (tap_address),
        .tap_data       (tap_data),
        .tap_we         (tap_we),
        .pipeline_flush (pipeline_flush),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: shadow contents, snapshot of the load in flight, the edge it started on.
    int m_shadow [N];
    int m_snap   [N];
    bit m_pending;
    int m_start;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 0;
            m_snap[i]   = 0;
        end
        m_pending = 1'b0;
        m_start   = -1000;
    endtask

    // A load started at edge s drives taps after edges s+1..s+N, flushes after s+N+1,
    // keeps the handshake gated after edges s..s+N, and can be followed at edge s+N+2.
    task automatic check_outputs();
        int  dd;
        bit  gated;
        dd    = cyc - m_start;
        gated = (dd >= 0) && (dd <= N);
        check("tap_we", 32'(tap_we), 32'((dd >= 1) && (dd <= N)));
        if ((dd >= 1) && (dd <= N)) begin
            check("tap_address", 32'(tap_address), 32'(dd - 1));
            check("tap_data", 32'(tap_data), 32'(m_snap[dd-1]));
        end
        check("pipeline_flush", 32'(pipeline_flush), 32'(dd == N + 1));
        check("done", 32'(done), 32'(dd == N + 1));
        check("busy", 32'(busy), 32'((dd >= 1) && (dd <= N + 1)));
        check("filt_valid", 32'(filt_valid), gated ? 32'd0 : 32'(up_valid));
        check("up_ready", 32'(up_ready), gated ? 32'd0 : 32'(filt_ready));
    endtask

    task automatic step(input bit c, input bit we, input logic [3:0] a, input logic [TW-1:0] d,
                        input bit uv, input bit fr);
        bit free;
        commit      = c;
        cfg_we      = we;
        cfg_address = a;
        cfg_data    = d;
        up_valid    = uv;
        filt_ready  = fr;
        @(posedge clock);
        cyc++;
        free = (cyc >= m_start + N + 2);
        if (free && (c || m_pending)) begin
            for (int i = 0; i < N; i++) begin
                m_snap[i] = (we && (int'(a) == i)) ? int'(d) : m_shadow[i];
            end
            m_start   = cyc;
            m_pending = 1'b0;
        end else if (c) begin
            m_pending = 1'b1;
        end
        if (we && (int'(a) < N)) begin
            m_shadow[int'(a)] = int'(d);
        end
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tap_we"}, 32'(tap_we), 32'd0);
        check({tag, "_tap_address"}, 32'(tap_address), 32'd0);
        check({tag, "_tap_data"}, 32'(tap_data), 32'd0);
        check({tag, "_flush"}, 32'(pipeline_flush), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_filt_valid"}, 32'(filt_valid), 32'd0);
        check({tag, "_up_ready"}, 32'(up_ready), 32'd0);
    endtask

    // Asserted between clock edges so the asynchronous clear is observed immediately.
    task automatic do_reset();
        commit     = 1'b0;
        cfg_we     = 1'b0;
        up_valid   = 1'b0;
        filt_ready = 1'b0;
        reset      = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check_all_zero("rst_hold");
        reset = 1'b1;
        cyc += 2;
    endtask

    initial begin
        cfg_address = '0;
        cfg_data    = '0;
        cfg_we      = 1'b0;
        commit      = 1'b0;
        up_valid    = 1'b0;
        filt_ready  = 1'b0;
        reset       = 1'b1;
        model_reset();
        #2;
        do_reset();

        // Ascending coefficients, then commit with handshake held high.
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 4'(i), 16'(i + 1), 1'b1, 1'b1);
        step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1);
        idle(14);
        $display("scenario ascending_load checks=%0d failures=%0d", n_checks, n_fail);

        // Shadow write mid-load plus a second commit while busy.
        step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1);
        idle(3);
        step(1'b0, 1'b1, 4'd3, 16'h7FFF, 1'b1, 1'b1);
        step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1);
        idle(26);
        $display("scenario pending_commit checks=%0d failures=%0d", n_checks, n_fail);

        // Out-of-range write is dropped; same-cycle write joins the snapshot.
        step(1'b0, 1'b1, 4'd12, 16'hDEAD, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd0, 16'h1234, 1'b1, 1'b0);
        idle(14);
        $display("scenario oob_and_forward checks=%0d failures=%0d", n_checks, n_fail);

        // Reset on the fifth LOAD cycle, then a commit must load zeros.
        step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1);
        idle(5);
        do_reset();
        idle(2);
        step(1'b1, 1'b0, 4'd0, '0, 1'b1, 1'b1);
        idle(13);
        $display("scenario reset_mid_load checks=%0d failures=%0d", n_checks, n_fail);

        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0,
                     4'($urandom_range(0, 15)), 16'($urandom),
                     1'($urandom), 1'($urandom));
            end
        end
        $display("scenario random checks=%0d failures=%0d", n_checks, n_fail);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_tap_controller.md
FILTER_TAP_CONTROLLER -- requirements
Module: filter_tap_controller

Interface
REQ-001 Parameter N_TAPS, default 9: number of filter taps loaded per commit, range 1..16.
REQ-002 Parameter TAP_WIDTH, default 16: coefficient width.
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 cfg_address  input  4  shadow-bank tap index.
REQ-006 cfg_data  input  TAP_WIDTH  coefficient to write.
REQ-007 cfg_we  input  1  shadow-bank write strobe.
REQ-008 commit  input  1  request to transfer the shadow bank into the filter.
REQ-009 up_valid  input  1  upstream sample valid.
REQ-010 up_ready  output  1  ready toward upstream.
REQ-011 filt_valid  output  1  sample valid toward the filter.
REQ-012 filt_ready  input  1  filter in_ready.
REQ-013 tap_address  output  4  filter tap address.
REQ-014 tap_data  output  TAP_WIDTH  filter tap data.
REQ-015 tap_we  output  1  filter tap write strobe.
REQ-016 pipeline_flush  output  1  filter flush, one-cycle pulse.
REQ-017 busy  output  1  high while not in IDLE.
REQ-018 done  output  1  one-cycle pulse at end of a load sequence.

Function
REQ-019 The shadow bank SHALL hold N_TAPS registers; cfg_we writes cfg_data to entry cfg_address in every state; writes with cfg_address >= N_TAPS are ignored.
REQ-020 The FSM SHALL have states IDLE, LOAD, FLUSH.
REQ-021 IDLE: on commit (or pending flag set), copy all shadow entries to the active bank, clear the pending flag, clear tap counter, go to LOAD.
REQ-022 When cfg_we and commit coincide in IDLE, the snapshot SHALL include the entry being written.
REQ-023 LOAD: tap_we=1, tap_address=counter, tap_data=active[counter] for exactly N_TAPS consecutive cycles, counter 0..N_TAPS-1 ascending; after the last tap go to FLUSH.
REQ-024 FLUSH: pipeline_flush=1 and done=1 for exactly one cycle, then IDLE.
REQ-025 Latency: commit sampled at edge k -> tap_we high after edges k+1..k+N_TAPS, flush/done after edge k+N_TAPS+1, busy low after edge k+N_TAPS+2.
REQ-026 commit while busy SHALL set a pending flag (multiple collapse to one); the pending load starts on the first IDLE cycle and uses the shadow contents at that time.
REQ-027 In IDLE: filt_valid=up_valid, up_ready=filt_ready; in LOAD and FLUSH: filt_valid=0, up_ready=0.
REQ-028 Shadow writes during LOAD/FLUSH SHALL NOT alter the active bank or the taps currently being loaded.
REQ-029 All outputs except filt_valid and up_ready SHALL be registered; tap_we, tap_data, tap_address change only on clock edges.
REQ-030 tap_address SHALL be zero-extended to 4 bits; tap_data driven from active bank unmodified.

Reset
REQ-031 reset low SHALL asynchronously force IDLE, clear shadow and active banks, pending flag and counter; tap_we=0, tap_address=0, tap_data=0, pipeline_flush=0, busy=0, done=0.
REQ-032 Reset asserted mid-LOAD SHALL abort the sequence without issuing pipeline_flush or done; no pending load survives reset.
REQ-033 After reset release, the first commit SHALL load all-zero taps unless the shadow was written.

Verification
REQ-034 Write shadow[i]=i+1 for i=0..8, commit -> tap_we high 9 cycles, addresses 0..8, data 1..9, then one flush+done pulse, busy low after 11 cycles.
REQ-035 up_valid=1, filt_ready=1 held during commit -> filt_valid and up_ready 0 for exactly 10 cycles (LOAD+FLUSH), pass-through otherwise.
REQ-036 Commit at cycle 0, cfg_we shadow[3]=0x7FFF at cycle 4, second commit at cycle 5 -> first load sends old shadow[3]; second load starts after first done and sends 0x7FFF.
REQ-037 cfg_we address 12 with N_TAPS=9, commit -> loaded taps unchanged from previous shadow contents.
REQ-038 Reset asserted at 5th LOAD cycle -> all outputs zero immediately, no flush/done; after release, commit loads zeros.
REQ-039 cfg_we shadow[0]=0x1234 and commit same cycle -> first tap_data=0x1234.
